// File: rtl/mcu_command_decoder.sv
// Command decoder behind the SPI controller: parses framed opcode-led commands into register-bus strobes.
// Optional feature: define MCU_DECODER_BURST_EN to build WRITE_BURST (opcode 8'h04).
module mcu_command_decoder #(
    parameter logic [7:0] STATUS_ID = 8'hFA
) (
    input  logic       i_master_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_master_data,
    input  logic       i_master_data_valid,
    input  logic       i_master_start,
    input  logic       i_master_end,
    output logic [7:0] o_response_data,
    output logic       o_response_data_valid,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_wr,
    output logic       o_reg_rd,
    input  logic [7:0] i_reg_rdata,
    output logic [7:0] o_error_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_OPCODE    = 3'd1,
        S_ADDR      = 3'd2,
        S_LEN       = 3'd3,
        S_DATA      = 3'd4,
        S_READ_WAIT = 3'd5,
        S_DONE      = 3'd6,
        S_DROP      = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        CMD_WRITE = 2'd0,
        CMD_READ  = 2'd1,
        CMD_BURST = 2'd2
    } cmd_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        if (value == 8'hFF) begin
            return 8'hFF;
        end else begin
            return value + 8'd1;
        end
    endfunction

    state_t     state_r, state_s, cur_s, byte_state_s;
    cmd_t       cmd_r, cmd_s;
    logic [7:0] reg_addr_r, reg_addr_s;
    logic [7:0] reg_wdata_r, reg_wdata_s;
    logic       reg_wr_r, reg_wr_s;
    logic       reg_rd_r, reg_rd_s;
    logic [7:0] resp_data_r, resp_data_s;
    logic       resp_valid_r, resp_valid_s;
    logic [7:0] err_cnt_r;
    logic       err_op_s, trunc_s;
`ifdef MCU_DECODER_BURST_EN
    logic [7:0] burst_cnt_r, burst_cnt_s;
    logic       burst_first_r, burst_first_s;
`endif

    // Next-state and next-output decode; start wins over the byte, the byte over end.
    always_comb begin
        state_s      = state_r;
        cmd_s        = cmd_r;
        reg_addr_s   = reg_addr_r;
        reg_wdata_s  = reg_wdata_r;
        reg_wr_s     = 1'b0;
        reg_rd_s     = 1'b0;
        resp_data_s  = resp_data_r;
        resp_valid_s = 1'b0;
        err_op_s     = 1'b0;
        trunc_s      = 1'b0;
`ifdef MCU_DECODER_BURST_EN
        burst_cnt_s   = burst_cnt_r;
        burst_first_s = burst_first_r;
`endif
        if (i_master_start) begin
            cur_s = S_OPCODE;
        end else begin
            cur_s = state_r;
        end
        byte_state_s = cur_s;

        if (i_master_data_valid) begin
            case (cur_s)
                S_OPCODE: begin
                    case (i_master_data)
                        8'h01: begin
                            resp_data_s  = STATUS_ID;
                            resp_valid_s = 1'b1;
                            byte_state_s = S_DONE;
                        end
                        8'h02: begin
                            cmd_s        = CMD_WRITE;
                            byte_state_s = S_ADDR;
                        end
                        8'h03: begin
                            cmd_s        = CMD_READ;
                            byte_state_s = S_ADDR;
                        end
`ifdef MCU_DECODER_BURST_EN
                        8'h04: begin
                            cmd_s        = CMD_BURST;
                            byte_state_s = S_ADDR;
                        end
`endif
                        default: begin
                            err_op_s     = 1'b1;
                            byte_state_s = S_DROP;
                        end
                    endcase
                end
                S_ADDR: begin
                    reg_addr_s = i_master_data;
`ifdef MCU_DECODER_BURST_EN
                    burst_first_s = 1'b1;
`endif
                    if (cmd_r == CMD_READ) begin
                        reg_rd_s     = 1'b1;
                        byte_state_s = S_READ_WAIT;
`ifdef MCU_DECODER_BURST_EN
                    end else if (cmd_r == CMD_BURST) begin
                        byte_state_s = S_LEN;
`endif
                    end else begin
                        byte_state_s = S_DATA;
                    end
                end
`ifdef MCU_DECODER_BURST_EN
                S_LEN: begin
                    // Remaining-minus-one count: LEN of 0 wraps to 255, i.e. 256 bytes.
                    burst_cnt_s  = i_master_data - 8'd1;
                    byte_state_s = S_DATA;
                end
`endif
                S_DATA: begin
                    reg_wdata_s = i_master_data;
                    reg_wr_s    = 1'b1;
`ifdef MCU_DECODER_BURST_EN
                    if (cmd_r == CMD_BURST) begin
                        // Increment before the next write so o_reg_addr holds after each strobe.
                        if (burst_first_r) begin
                            reg_addr_s = reg_addr_r;
                        end else begin
                            reg_addr_s = reg_addr_r + 8'd1;
                        end
                        burst_first_s = 1'b0;
                        if (burst_cnt_r == 8'd0) begin
                            byte_state_s = S_DONE;
                        end else begin
                            burst_cnt_s  = burst_cnt_r - 8'd1;
                            byte_state_s = S_DATA;
                        end
                    end else begin
                        byte_state_s = S_DONE;
                    end
`else
                    byte_state_s = S_DONE;
`endif
                end
                default: begin
                    byte_state_s = cur_s;
                end
            endcase
        end else begin
            byte_state_s = cur_s;
        end

        if (i_master_end) begin
            if ((byte_state_s == S_ADDR) || (byte_state_s == S_LEN) ||
                (byte_state_s == S_DATA) || (byte_state_s == S_READ_WAIT)) begin
                trunc_s = 1'b1;
            end else begin
                trunc_s = 1'b0;
            end
            state_s = S_IDLE;
        end else if ((cur_s == S_READ_WAIT) && (byte_state_s == S_READ_WAIT)) begin
            state_s = S_DONE;
        end else begin
            state_s = byte_state_s;
        end

        // Read data arrives while o_reg_rd is high; the response goes out regardless of frame state.
        if (reg_rd_r) begin
            resp_data_s  = i_reg_rdata;
            resp_valid_s = 1'b1;
        end else begin
            resp_data_s = resp_data_s;
        end
    end

    // FSM state register.
    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cmd_r         <= CMD_WRITE;
            reg_addr_r    <= 8'h00;
            reg_wdata_r   <= 8'h00;
            reg_wr_r      <= 1'b0;
            reg_rd_r      <= 1'b0;
            resp_data_r   <= 8'h00;
            resp_valid_r  <= 1'b0;
            err_cnt_r     <= 8'h00;
`ifdef MCU_DECODER_BURST_EN
            burst_cnt_r   <= 8'h00;
            burst_first_r <= 1'b0;
`endif
        end else begin
            cmd_r         <= cmd_s;
            reg_addr_r    <= reg_addr_s;
            reg_wdata_r   <= reg_wdata_s;
            reg_wr_r      <= reg_wr_s;
            reg_rd_r      <= reg_rd_s;
            resp_data_r   <= resp_data_s;
            resp_valid_r  <= resp_valid_s;
            if (err_op_s || trunc_s) begin
                err_cnt_r <= sat_inc(err_cnt_r);
            end else begin
                err_cnt_r <= err_cnt_r;
            end
`ifdef MCU_DECODER_BURST_EN
            burst_cnt_r   <= burst_cnt_s;
            burst_first_r <= burst_first_s;
`endif
        end
    end

    assign o_response_data       = resp_data_r;
    assign o_response_data_valid = resp_valid_r;
    assign o_reg_addr            = reg_addr_r;
    assign o_reg_wdata           = reg_wdata_r;
    assign o_reg_wr              = reg_wr_r;
    assign o_reg_rd              = reg_rd_r;
    assign o_error_count         = err_cnt_r;

endmodule

// File: tb/tb_mcu_command_decoder.sv
// Scoreboard bench for mcu_command_decoder: expected strobes are queued with their cycle and
// matched by a negedge monitor; each scenario task checks error count and drained queue inline.
module tb_mcu_command_decoder;

    logic       clk = 1'b0;
    logic       i_reset_n;
    logic [7:0] i_master_data;
    logic       i_master_data_valid, i_master_start, i_master_end;
    logic [7:0] o_response_data;
    logic       o_response_data_valid;
    logic [7:0] o_reg_addr, o_reg_wdata;
    logic       o_reg_wr, o_reg_rd;
    logic [7:0] i_reg_rdata;
    logic [7:0] o_error_count;

    mcu_command_decoder #(.STATUS_ID(8'hFA)) dut (
        .i_master_clk(clk), .i_reset_n(i_reset_n),
        .i_master_data(i_master_data), .i_master_data_valid(i_master_data_valid),
        .i_master_start(i_master_start), .i_master_end(i_master_end),
        .o_response_data(o_response_data), .o_response_data_valid(o_response_data_valid),
        .o_reg_addr(o_reg_addr), .o_reg_wdata(o_reg_wdata),
        .o_reg_wr(o_reg_wr), .o_reg_rd(o_reg_rd),
        .i_reg_rdata(i_reg_rdata), .o_error_count(o_error_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;   // 0 write, 1 read, 2 response
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        int         n_hi;
        int         kind;
        logic [7:0] oa, od;
        exp_t       e;
        if (i_reset_n) begin
            n_hi = int'(o_reg_wr) + int'(o_reg_rd) + int'(o_response_data_valid);
            if (n_hi != 0) begin
                kind = o_reg_wr ? 0 : (o_reg_rd ? 1 : 2);
                oa   = (kind == 2) ? 8'h00 : o_reg_addr;
                od   = (kind == 0) ? o_reg_wdata : ((kind == 2) ? o_response_data : 8'h00);
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_strobe: cyc=%0d kind=%0d addr=%h data=%h, required no strobe",
                             cyc, kind, oa, od);
                end else begin
                    e = exp_q.pop_front();
                    if (n_hi !== 1 || kind !== e.kind || cyc !== e.cyc || oa !== e.addr || od !== e.data) begin
                        miscompares++;
                        $display("FAIL strobe: got n=%0d kind=%0d cyc=%0d addr=%h data=%h, required kind=%0d cyc=%0d addr=%h data=%h",
                                 n_hi, kind, cyc, oa, od, e.kind, e.cyc, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic exp_push(input int kind, input int lat, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.kind = kind; e.cyc = cyc + 1 + lat; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // One byte cycle, then one idle cycle in which i_reg_rdata = rdv (the o_reg_rd cycle for address bytes).
    task automatic send_byte(input logic [7:0] b, input logic s, input logic e, input logic [7:0] rdv);
        @(posedge clk); #1;
        i_master_data = b; i_master_data_valid = 1'b1; i_master_start = s; i_master_end = e;
        @(posedge clk); #1;
        i_master_data_valid = 1'b0; i_master_start = 1'b0; i_master_end = 1'b0; i_reg_rdata = rdv;
        @(posedge clk); #1;
        i_reg_rdata = 8'h00;
    endtask

    task automatic pulse(input logic s, input logic e);
        @(posedge clk); #1;
        i_master_start = s; i_master_end = e;
        @(posedge clk); #1;
        i_master_start = 1'b0; i_master_end = 1'b0;
    endtask

    task automatic check_frame_end(input string name);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() !== 0 || o_error_count !== exp_err[7:0]) begin
            miscompares++;
            $display("FAIL %s: pending=%0d err_count=%h, required pending=0 err_count=%h",
                     name, exp_q.size(), o_error_count, exp_err[7:0]);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0; i_master_data = 8'h00; i_master_data_valid = 1'b0;
        i_master_start = 1'b0; i_master_end = 1'b0; i_reg_rdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({o_response_data, o_response_data_valid, o_reg_addr, o_reg_wdata, o_reg_wr, o_reg_rd, o_error_count} !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_values: resp=%h/%b addr=%h wdata=%h wr=%b rd=%b err=%h, required all zero",
                     o_response_data, o_response_data_valid, o_reg_addr, o_reg_wdata, o_reg_wr, o_reg_rd, o_error_count);
        end
        @(negedge clk) i_reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_reg();
        pulse(1'b1, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0, 8'h00);
        send_byte(8'h10, 1'b0, 1'b0, 8'h00);
        exp_push(0, 1, 8'h10, 8'h5A);
        send_byte(8'h5A, 1'b0, 1'b0, 8'h00);
        pulse(1'b0, 1'b1);
        check_frame_end("write_reg");
        // Last byte coincides with end: byte consumed first, so no truncation.
        send_byte(8'h02, 1'b1, 1'b0, 8'h00);
        send_byte(8'h33, 1'b0, 1'b0, 8'h00);
        exp_push(0, 1, 8'h33, 8'hE7);
        send_byte(8'hE7, 1'b0, 1'b1, 8'h00);
        check_frame_end("write_reg_end_same_cycle");
    endtask

    task automatic test_read_reg();
        pulse(1'b1, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0, 8'h00);
        exp_push(1, 1, 8'h22, 8'h00);
        exp_push(2, 2, 8'h00, 8'hC3);
        send_byte(8'h22, 1'b0, 1'b0, 8'hC3);
        pulse(1'b0, 1'b1);
        check_frame_end("read_reg");
    endtask

    task automatic test_status();
        pulse(1'b1, 1'b0);
        exp_push(2, 1, 8'h00, 8'hFA);
        send_byte(8'h01, 1'b0, 1'b0, 8'h00);
        send_byte(8'h99, 1'b0, 1'b0, 8'h00);
        pulse(1'b0, 1'b1);
        check_frame_end("get_status");
        exp_push(2, 1, 8'h00, 8'hFA);
        send_byte(8'h01, 1'b1, 1'b0, 8'h00);
        pulse(1'b0, 1'b1);
        check_frame_end("get_status_start_same_cycle");
    endtask

`ifdef MCU_DECODER_BURST_EN
    task automatic test_burst();
        logic [7:0] a;
        send_byte(8'h04, 1'b1, 1'b0, 8'h00);
        send_byte(8'hFE, 1'b0, 1'b0, 8'h00);
        send_byte(8'h03, 1'b0, 1'b0, 8'h00);
        exp_push(0, 1, 8'hFE, 8'hA1);
        send_byte(8'hA1, 1'b0, 1'b0, 8'h00);
        exp_push(0, 1, 8'hFF, 8'hA2);
        send_byte(8'hA2, 1'b0, 1'b0, 8'h00);
        exp_push(0, 1, 8'h00, 8'hA3);
        send_byte(8'hA3, 1'b0, 1'b0, 8'h00);
        send_byte(8'hA4, 1'b0, 1'b0, 8'h00);
        pulse(1'b0, 1'b1);
        check_frame_end("burst_3");
        send_byte(8'h04, 1'b1, 1'b0, 8'h00);
        send_byte(8'h80, 1'b0, 1'b0, 8'h00);
        send_byte(8'h00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 256; i++) begin
            a = 8'h80 + i[7:0];
            exp_push(0, 1, a, i[7:0] ^ 8'h5C);
            send_byte(i[7:0] ^ 8'h5C, 1'b0, 1'b0, 8'h00);
        end
        send_byte(8'hEE, 1'b0, 1'b0, 8'h00);
        pulse(1'b0, 1'b1);
        check_frame_end("burst_len0_256");
        send_byte(8'h04, 1'b1, 1'b0, 8'h00);
        send_byte(8'h40, 1'b0, 1'b0, 8'h00);
        send_byte(8'h05, 1'b0, 1'b0, 8'h00);
        exp_push(0, 1, 8'h40, 8'h01);
        send_byte(8'h01, 1'b0, 1'b0, 8'h00);
        pulse(1'b0, 1'b1);
        exp_err++;
        check_frame_end("burst_truncated");
    endtask
`endif

    task automatic test_errors();
        send_byte(8'h7F, 1'b1, 1'b0, 8'h00);
        pulse(1'b0, 1'b1);
        exp_err++;
        check_frame_end("bad_opcode");
        send_byte(8'h02, 1'b1, 1'b0, 8'h00);
        send_byte(8'h10, 1'b0, 1'b0, 8'h00);
        pulse(1'b0, 1'b1);
        exp_err++;
        check_frame_end("truncated_write");
`ifndef MCU_DECODER_BURST_EN
        send_byte(8'h04, 1'b1, 1'b0, 8'h00);
        send_byte(8'h10, 1'b0, 1'b0, 8'h00);
        pulse(1'b0, 1'b1);
        exp_err++;
        check_frame_end("burst_opcode_disabled");
`endif
        // End in the same cycle as the read address: truncated, but the response still goes out.
        send_byte(8'h03, 1'b1, 1'b0, 8'h00);
        exp_push(1, 1, 8'h6B, 8'h00);
        exp_push(2, 2, 8'h00, 8'h3C);
        send_byte(8'h6B, 1'b0, 1'b1, 8'h3C);
        exp_err++;
        check_frame_end("truncated_read");
        for (int i = 0; i < 300; i++) begin
            send_byte(8'h7F, 1'b1, 1'b1, 8'h00);
            if (exp_err < 255) exp_err++;
        end
        check_frame_end("error_saturation");
    endtask

    task automatic test_restart();
        pulse(1'b1, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0, 8'h00);
        send_byte(8'h10, 1'b0, 1'b0, 8'h00);
        pulse(1'b1, 1'b0);
        exp_push(2, 1, 8'h00, 8'hFA);
        send_byte(8'h01, 1'b0, 1'b0, 8'h00);
        pulse(1'b0, 1'b1);
        check_frame_end("restart_mid_write");
    endtask

    task automatic test_reset_mid();
`ifdef MCU_DECODER_BURST_EN
        send_byte(8'h04, 1'b1, 1'b0, 8'h00);
        send_byte(8'h30, 1'b0, 1'b0, 8'h00);
        send_byte(8'h05, 1'b0, 1'b0, 8'h00);
        exp_push(0, 1, 8'h30, 8'h11);
        send_byte(8'h11, 1'b0, 1'b0, 8'h00);
`else
        send_byte(8'h02, 1'b1, 1'b0, 8'h00);
        send_byte(8'h30, 1'b0, 1'b0, 8'h00);
`endif
        i_reset_n = 1'b0;
        #1;
        vectors++;
        if ({o_response_data, o_response_data_valid, o_reg_addr, o_reg_wdata, o_reg_wr, o_reg_rd, o_error_count} !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_mid_frame: addr=%h wdata=%h err=%h resp=%h, required all zero",
                     o_reg_addr, o_reg_wdata, o_error_count, o_response_data);
        end
        exp_err = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) i_reset_n = 1'b1;
        @(posedge clk); #1;
        send_byte(8'h02, 1'b0, 1'b0, 8'h00);
        send_byte(8'h44, 1'b0, 1'b0, 8'h00);
        send_byte(8'h55, 1'b0, 1'b0, 8'h00);
        check_frame_end("bytes_ignored_after_reset");
        vectors++;
        if (o_reg_addr !== 8'h00) begin
            miscompares++;
            $display("FAIL addr_after_reset: got %h, required 00", o_reg_addr);
        end
    endtask

    initial begin
        test_reset();
        test_write_reg();
        test_read_reg();
        test_status();
`ifdef MCU_DECODER_BURST_EN
        test_burst();
`endif
        test_errors();
        test_restart();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
